// File: rtl/axis_chain_pkg.sv
// axis_chain_pkg: shared pixel types, widths and {pad,R,G,B} pack/unpack helpers for the axis_chain video path
package axis_chain_pkg;
  localparam int PIX_W = 32;
  localparam int PAD_BITS = 8;
  typedef struct packed { logic [7:0] r, g, b; } rgb_t;
  typedef struct packed { logic [8:0] r, g, b; } rgb_sum_t;
  typedef struct packed { logic [9:0] r, g, b; } rgb_sum10_t;
  typedef struct packed { logic [PAD_BITS-1:0] pad; rgb_t rgb; } pix_t;
  function automatic pix_t unpack_pix(input logic [PIX_W-1:0] d);
    return d;
  endfunction
  function automatic logic [PIX_W-1:0] pack_pix(input rgb_t p);
    return {{PAD_BITS{1'b0}}, p};
  endfunction
endpackage

// File: rtl/axis_chain_box_down2.sv
// axis_box_down2: 2x2 box filter with 2:1 decimation; clk/rst, s_pix/s_valid/s_user/s_ready in, m_pix/m_valid/m_ready/m_last/m_user registered out; AXIS_CHAIN_ROUND_EN selects rounding over truncation
module axis_box_down2
  import axis_chain_pkg::*;
#(
  parameter int IN_W = 640,
  parameter int IN_H = 480
) (
  input  logic clk,
  input  logic rst,
  input  rgb_t s_pix,
  input  logic s_valid,
  input  logic s_user,
  output logic s_ready,
  output rgb_t m_pix,
  output logic m_valid,
  input  logic m_ready,
  output logic m_last,
  output logic m_user
);
  localparam int XW = $clog2(IN_W);
  localparam int YW = $clog2(IN_H);
  logic [XW-1:0] x, xc;
  logic [YW-1:0] y, yc;
  logic acc;
  rgb_t hold;
  rgb_sum_t h, lb_q;
  rgb_sum_t lbuf [IN_W/2];
  rgb_sum10_t s;
  function automatic logic [7:0] scale(input logic [9:0] v);
`ifdef AXIS_CHAIN_ROUND_EN
    logic [10:0] t;
    t = {1'b0, v} + 11'd2;
    return (t >> 2) > 11'd255 ? 8'hff : 8'(t >> 2);
`else
    return 8'(v >> 2);
`endif
  endfunction
  assign s_ready = !m_valid || m_ready;
  assign acc = s_valid && s_ready;
  assign xc = s_user ? '0 : x;
  assign yc = s_user ? '0 : y;
  assign lb_q = lbuf[xc[XW-1:1]];
  assign h = '{{1'b0, hold.r} + {1'b0, s_pix.r}, {1'b0, hold.g} + {1'b0, s_pix.g}, {1'b0, hold.b} + {1'b0, s_pix.b}};
  assign s = '{{1'b0, lb_q.r} + {1'b0, h.r}, {1'b0, lb_q.g} + {1'b0, h.g}, {1'b0, lb_q.b} + {1'b0, h.b}};
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      m_valid <= 1'b0;
      m_pix <= '0;
      m_last <= 1'b0;
      m_user <= 1'b0;
    end else begin
      if (acc) begin
        x <= xc == XW'(IN_W-1) ? '0 : xc + XW'(1);
        y <= xc != XW'(IN_W-1) ? yc : yc == YW'(IN_H-1) ? '0 : yc + YW'(1);
      end
      if (acc && xc[0] && yc[0]) begin
        m_valid <= 1'b1;
        m_pix <= '{scale(s.r), scale(s.g), scale(s.b)};
        m_last <= xc[XW-1:1] == (XW-1)'(IN_W/2-1);
        m_user <= xc == XW'(1) && yc == YW'(1);
      end else if (m_ready) m_valid <= 1'b0;
    end
  end
  // even rows only write and odd rows only read, so one access per entry per cycle
  always_ff @(posedge clk) begin
    if (acc && !xc[0]) hold <= s_pix;
    if (acc && xc[0] && !yc[0]) lbuf[xc[XW-1:1]] <= h;
  end
endmodule

// File: rtl/axis_chain_top.sv
// axis_chain_top: RGB AXI4-Stream 2x2 box downscaler; aclk/aresetn (sync, active-high), s_axis_* 32-bit pixel in, m_axis_* half-resolution pixel out; AXIS_CHAIN_ROUND_EN enables rounding
module axis_chain_top
  import axis_chain_pkg::*;
#(
  parameter int IN_W = 640,
  parameter int IN_H = 480
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [PIX_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser
);
  pix_t in_pix;
  rgb_t out_rgb;
  logic unused_in;
  assign in_pix = unpack_pix(s_axis_tdata);
  assign unused_in = ^{s_axis_tlast, in_pix.pad};
  axis_box_down2 #(.IN_W(IN_W), .IN_H(IN_H)) u_box (
    .clk(aclk),
    .rst(aresetn),
    .s_pix(in_pix.rgb),
    .s_valid(s_axis_tvalid),
    .s_user(s_axis_tuser),
    .s_ready(s_axis_tready),
    .m_pix(out_rgb),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready),
    .m_last(m_axis_tlast),
    .m_user(m_axis_tuser)
  );
  assign m_axis_tdata = pack_pix(out_rgb);
endmodule

// File: tb/tb_axis_chain_top.sv
// tb_axis_chain_top: table-driven and directed bench for axis_chain_top on a small 8x4 frame with a frame-level golden model
module tb_axis_chain_top;
  localparam int W = 8;
  localparam int H = 4;
  typedef struct { logic [23:0] d; logic u; logic l; } exp_t;
  typedef struct { logic [23:0] a, b, c, d, et, er; } vec_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tlast = 1'b0;
  logic s_axis_tuser = 1'b0;
  logic s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic m_axis_tready = 1'b1;
  logic bp = 1'b0;
  int checks = 0;
  int errs = 0;
  int stalls = 0;
  logic [23:0] img [H][W];
  exp_t expq[$];
  exp_t e_mon;
  vec_t vt[6];
  logic [23:0] ev;
  logic stall_q = 1'b0;
  logic [31:0] data_q = '0;

  always #5 aclk = ~aclk;

  axis_chain_top #(.IN_W(W), .IN_H(H)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [23:0] box(input int ox, input int oy);
    logic [23:0] r;
    int s;
    r = '0;
    for (int c = 0; c < 24; c += 8) begin
      s = int'(img[2*oy][2*ox][c+:8]) + int'(img[2*oy][2*ox+1][c+:8])
        + int'(img[2*oy+1][2*ox][c+:8]) + int'(img[2*oy+1][2*ox+1][c+:8]);
`ifdef AXIS_CHAIN_ROUND_EN
      s = (s + 2) / 4;
      if (s > 255) s = 255;
`else
      s = s / 4;
`endif
      r[c+:8] = 8'(s);
    end
    return r;
  endfunction

  always @(posedge aclk) begin
    #1;
    m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      if (stall_q) begin
        chk("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("stall_data", m_axis_tdata, data_q);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_beat: got data %h, none expected", m_axis_tdata);
        end else begin
          e_mon = expq.pop_front();
          chk("tdata", m_axis_tdata, {8'h00, e_mon.d});
          chk("tuser", {31'd0, m_axis_tuser}, {31'd0, e_mon.u});
          chk("tlast", {31'd0, m_axis_tlast}, {31'd0, e_mon.l});
        end
      end
    end
    stall_q = !aresetn && m_axis_tvalid && !m_axis_tready;
    data_q = m_axis_tdata;
  end

  task automatic send_pix(input logic [23:0] p, input logic u, input logic l);
    int n = 0;
    logic a = 1'b0;
    s_axis_tdata = {8'hA5, p};
    s_axis_tuser = u;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    while (!a && n < 200) begin
      @(negedge aclk);
      a = s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!a) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: pixel %h not accepted within 200 cycles", p);
    end
    stalls += n - 1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
  endtask

  task automatic send_pixels(input int npix, input logic u0);
    for (int i = 0; i < npix; i++) send_pix(img[i/W][i%W], i == 0 ? u0 : 1'b0, i % W == W - 1);
  endtask

  task automatic send_frame(input int npix, input logic u0);
    for (int oy = 0; oy < H/2; oy++)
      for (int ox = 0; ox < W/2; ox++)
        if ((2*oy+1)*W + 2*ox + 1 < npix) expq.push_back('{box(ox, oy), ox == 0 && oy == 0, ox == W/2 - 1});
    send_pixels(npix, u0);
  endtask

  task automatic rand_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 24'($urandom());
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(posedge aclk);
    #1;
    chk("drain_left", expq.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{24'h102030, 24'h102030, 24'h102030, 24'h102030, 24'h102030, 24'h102030};
    vt[1] = '{24'h00FFFF, 24'h01FFFF, 24'h02FFFF, 24'h03FEFE, 24'h01FEFE, 24'h02FFFF};
    vt[2] = '{24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
    vt[3] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vt[4] = '{24'h040404, 24'h000000, 24'h000000, 24'h000000, 24'h010101, 24'h010101};
    vt[5] = '{24'h018007, 24'h018000, 24'h008000, 24'h008100, 24'h008001, 24'h018002};
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("reset_tdata", m_axis_tdata, 32'd0);
    chk("reset_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("reset_tuser", {31'd0, m_axis_tuser}, 32'd0);
    aresetn = 1'b0;
    chk("ready_after_reset", {31'd0, s_axis_tready}, 32'd1);
    stalls = 0;
    foreach (vt[i]) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          img[y][x] = y % 2 == 0 ? (x % 2 == 0 ? vt[i].a : vt[i].b) : (x % 2 == 0 ? vt[i].c : vt[i].d);
`ifdef AXIS_CHAIN_ROUND_EN
      ev = vt[i].er;
`else
      ev = vt[i].et;
`endif
      for (int k = 0; k < W*H/4; k++) expq.push_back('{ev, k == 0, k % (W/2) == W/2 - 1});
      send_pixels(W*H, 1'b1);
    end
    chk("throughput_stalls", stalls, 32'd0);
    drain();
    bp = 1'b1;
    repeat (2) begin
      rand_img();
      send_frame(W*H, 1'b1);
    end
    drain();
    bp = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    rand_img();
    send_frame(26, 1'b1);
    aresetn = 1'b1;
    expq.delete();
    @(posedge aclk);
    #1;
    chk("valid_in_reset_1", {31'd0, m_axis_tvalid}, 32'd0);
    @(posedge aclk);
    #1;
    chk("valid_in_reset_2", {31'd0, m_axis_tvalid}, 32'd0);
    aresetn = 1'b0;
    rand_img();
    send_frame(W*H, 1'b0);
    drain();
    rand_img();
    send_frame(29, 1'b1);
    rand_img();
    send_frame(W*H, 1'b1);
    drain();
    repeat (3) begin
      rand_img();
      send_frame(W*H, 1'b1);
      repeat (20) @(posedge aclk);
      #1;
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
